// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the pipeline sequencer.
// Stats signals exist only when PIPE_CTRL_STALL_STATS_EN is defined.
interface pipe_ctrl_if;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        mc_start;
   logic [31:0] excepttype_i;
   logic [31:0] cp0_epc_i;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        mc_done;
   logic        busy;
`ifdef PIPE_CTRL_STALL_STATS_EN
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;

   modport master (
      output stallreq_id, stallreq_ex, mc_start,
      output excepttype_i, cp0_epc_i,
      input  stall, flush, new_pc, mc_done, busy,
      input  stall_cycles, flush_count
   );

   modport slave (
      input  stallreq_id, stallreq_ex, mc_start,
      input  excepttype_i, cp0_epc_i,
      output stall, flush, new_pc, mc_done, busy,
      output stall_cycles, flush_count
   );
`else
   modport master (
      output stallreq_id, stallreq_ex, mc_start,
      output excepttype_i, cp0_epc_i,
      input  stall, flush, new_pc, mc_done, busy
   );

   modport slave (
      input  stallreq_id, stallreq_ex, mc_start,
      input  excepttype_i, cp0_epc_i,
      output stall, flush, new_pc, mc_done, busy
   );
`endif
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall arbitration, multi-cycle EX timing, redirects.
// Optional stall/flush statistics under PIPE_CTRL_STALL_STATS_EN.
module pipe_ctrl #(
   parameter int unsigned MC_CYCLES  = 4,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
   parameter logic [31:0] ERET_CODE  = 32'h0000_000e
) (
   input  logic       clk,
   input  logic       rst,
   pipe_ctrl_if.slave bus
);

   typedef enum logic {
      RUN     = 1'b0,
      MC_BUSY = 1'b1
   } state_e;

   localparam logic [7:0] CNT_INIT = 8'(MC_CYCLES - 2);
   localparam logic [5:0] STALL_EX = 6'b001111;
   localparam logic [5:0] STALL_ID = 6'b000111;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   logic       exc;
   logic       mc_hold;
   logic       mc_last;
   logic       mc_go;
   logic [5:0] req_stall;

   assign exc     = |bus.excepttype_i;
   assign mc_hold = (state_q == MC_BUSY) && (cnt_q != 8'd0);
   assign mc_last = (state_q == MC_BUSY) && (cnt_q == 8'd0);
   assign mc_go   = (state_q == RUN) && bus.mc_start;

   always_comb begin
      req_stall = 6'b000000;
      if (bus.stallreq_ex)
         req_stall = STALL_EX;
      else if (bus.stallreq_id)
         req_stall = STALL_ID;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (exc) begin
         state_d = RUN;
         cnt_d   = 8'd0;
      end else if (mc_hold) begin
         cnt_d = cnt_q - 8'd1;
      end else if (mc_last) begin
         state_d = RUN;
         cnt_d   = 8'd0;
      end else if (mc_go) begin
         state_d = MC_BUSY;
         cnt_d   = CNT_INIT;
      end
   end

   // An exception aborts any in-flight op, so busy and mc_done drop too.
   always_comb begin
      bus.stall   = 6'b000000;
      bus.flush   = 1'b0;
      bus.new_pc  = 32'h0;
      bus.mc_done = 1'b0;
      bus.busy    = 1'b0;
      if (exc) begin
         bus.flush = 1'b1;
         if (bus.excepttype_i == ERET_CODE)
            bus.new_pc = bus.cp0_epc_i;
         else
            bus.new_pc = EXC_VECTOR;
      end else if (mc_hold) begin
         bus.stall = STALL_EX;
         bus.busy  = 1'b1;
      end else if (mc_last) begin
         bus.stall   = req_stall;
         bus.mc_done = 1'b1;
         bus.busy    = 1'b1;
      end else if (mc_go) begin
         bus.stall = STALL_EX;
         bus.busy  = 1'b1;
      end else begin
         bus.stall = req_stall;
      end
   end

`ifdef PIPE_CTRL_STALL_STATS_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [15:0] flush_count_q, flush_count_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= 32'h0;
         flush_count_q  <= 16'h0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (bus.stall[0] && !bus.flush && (stall_cycles_q != 32'hFFFF_FFFF))
         stall_cycles_d = stall_cycles_q + 32'd1;
      if (bus.flush && (flush_count_q != 16'hFFFF))
         flush_count_d = flush_count_q + 16'd1;
   end

   assign bus.stall_cycles = stall_cycles_q;
   assign bus.flush_count  = flush_count_q;
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencer for the 5-stage MIPS core. Drives the per-stage stall vector and the flush/new-PC redirect used by the pc, if_id, id_ex, ex_mem and mem_wb stage registers.
- Arbitrates stall requests from ID and EX, and times fixed-latency multi-cycle EX operations (div/madd) with an internal counter.
- Handles exception and ERET redirects.

Parameters:
- MC_CYCLES, 4: total cycles a multi-cycle EX op occupies, counting its start cycle. Legal range 2..255.
- EXC_VECTOR, 32'h0000_0020: redirect PC for every exception except ERET.
- ERET_CODE, 32'h0000_000e: excepttype_i value meaning ERET.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- stallreq_id, in, 1: ID needs a stall (load-use hazard).
- stallreq_ex, in, 1: EX needs a stall.
- mc_start, in, 1: EX begins a multi-cycle op this cycle.
- excepttype_i, in, 32: exception code from MEM; 0 means no exception.
- cp0_epc_i, in, 32: current CP0 EPC.
- stall, out, 6: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
- flush, out, 1: flush all stage registers.
- new_pc, out, 32: redirect target, valid when flush=1.
- mc_done, out, 1: one-cycle pulse when the multi-cycle result is ready.
- busy, out, 1: a multi-cycle op is in progress.

Behaviour:
- Clock and reset: clk is the clock. rst is synchronous, active-high.
- Reset (rst=1 at a clk edge): state=RUN, cnt=0. While in RUN with inputs idle, outputs are stall=0, flush=0, new_pc=0, mc_done=0, busy=0.
- Registered vs combinational: state and cnt are registered. stall, flush, new_pc and mc_done are combinational from state, cnt and inputs, so there is zero-cycle latency from a request to its effect.
- States: RUN and MC_BUSY. cnt is 8 bits.
- Priority within a cycle, highest first:
  - excepttype_i != 0
  - MC_BUSY with cnt != 0
  - stallreq_ex
  - stallreq_id
- Exception (excepttype_i != 0):
  - flush=1, stall=6'b000000.
  - new_pc = cp0_epc_i if excepttype_i == ERET_CODE, else EXC_VECTOR.
  - Next state=RUN, cnt=0; any in-flight multi-cycle op is aborted with no mc_done.
  - mc_start in the same cycle is ignored.
- RUN:
  - mc_start=1 and no exception: stall=6'b001111, next state=MC_BUSY, cnt=MC_CYCLES-2.
  - Otherwise stallreq_ex gives stall=6'b001111; stallreq_id gives stall=6'b000111; neither gives 0.
- MC_BUSY:
  - cnt != 0: stall=6'b001111, cnt decrements, busy=1.
  - cnt == 0: mc_done=1, busy=1, next state=RUN. stall in this cycle is derived from stallreq_ex/stallreq_id only.
  - mc_start while in MC_BUSY is ignored.
- Timing example, MC_CYCLES=4: mc_start sampled in cycle T gives stall=001111 in T, T+1 and T+2; mc_done=1 in T+3 with the stall released.
- MC_CYCLES=2: stall in T only; mc_done in T+1.
- flush is never asserted together with a nonzero stall.
- new_pc=0 whenever flush=0.
- Reset mid-operation: rst overrides everything; MC_BUSY returns to RUN with no mc_done.

Optional Feature:
- Macro PIPE_CTRL_STALL_STATS_EN.
- Defined:
  - Extra output stall_cycles[31:0]. Increments on every cycle with stall[0]=1, except when flush=1.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst.
  - Also extra output flush_count[15:0], which increments on each flush and saturates.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst 2 cycles with excepttype_i=0 and all requests low, then release -> stall=0, flush=0, new_pc=0, busy=0.
- Stall requests: stallreq_id=1 alone -> stall=000111; stallreq_id=1 with stallreq_ex=1 -> stall=001111; both low -> stall=0, all in the same cycle.
- Multi-cycle op, MC_CYCLES=4: mc_start at T -> stall=001111 and busy=1 in T..T+2; mc_done=1 only in T+3; stall=0 in T+3; busy=0 in T+4.
- Exception abort: mc_start at T, excepttype_i=32'h1 at T+1 -> T+1: flush=1, stall=0, new_pc=32'h20; T+2: busy=0; mc_done never pulses.
- ERET redirect: excepttype_i=32'he with cp0_epc_i=32'h0000_1234 -> flush=1, new_pc=32'h0000_1234. Same cycle with mc_start=1 -> no MC_BUSY entry.
- Stats (PIPE_CTRL_STALL_STATS_EN defined): 3-cycle multi-cycle stall plus 2 cycles of stallreq_id -> stall_cycles=5; one exception -> flush_count=1.
